asteroid_scheduler: RTL
=======================

ASTEROID_SCHEDULER -- requirements
Module: asteroid_scheduler

Interface
REQ-001 Parameters SHALL be:
- N_SLOTS, 8, number of asteroid slots
- SPAWN_INTERVAL, 30, frames between spawn attempts
- DY, 3, downward pixels per frame
- H_RES, 640; V_RES, 480; SCREEN_CORDW, 16, coordinate width.
REQ-002 Ports SHALL be (one clock; reset asynchronous, active-high):
- clk_pix  in  1  pixel clock; all logic on rising edge
- rst  in  1  asynchronous active-high reset
- frame  in  1  one-cycle pulse at start of each frame
- en  in  1  obstacle enable (switch level)
- clear  in  1  one-cycle pulse; deactivate all slots
- hit_mask  in  N_SLOTS  per-slot collision pulses
- ast_x  out  N_SLOTS x SCREEN_CORDW  slot x positions
- ast_y  out  N_SLOTS x SCREEN_CORDW  slot y positions
- active  out  N_SLOTS  slot visible/valid
- busy  out  1  update pass in progress
- update_done  out  1  one-cycle pulse at end of pass

Function
REQ-003 FSM states SHALL be IDLE, UPDATE, SPAWN, DONE; busy SHALL be 1 in UPDATE and SPAWN.
REQ-004 IDLE -> UPDATE with idx=0 SHALL occur on frame=1 while en=1; frame with en=0 SHALL be ignored and positions held.
REQ-005 UPDATE SHALL process one slot per cycle (idx 0..N_SLOTS-1), then go to SPAWN.
REQ-006 Active slot update: y <= y+DY; x <= x+dx, where dx is the slot's stored direction (-1, 0, +1), in SCREEN_CORDW-bit unsigned arithmetic.
REQ-007 If new y >= V_RES or new x >= H_RES (including wrap below 0), the slot SHALL be deactivated; its x/y SHALL still take the new values.
REQ-008 Inactive slots SHALL be untouched in UPDATE.
REQ-009 SPAWN, spawn timer != 0: timer SHALL decrement, no spawn.
REQ-010 SPAWN, timer == 0, with a free slot:
- lowest-index inactive slot gets x = lfsr[8:0]+64 (range 64..575), y=0, active=1
- dx encoding lfsr[10:9]: 00 -> -1, 01/11 -> 0, 10 -> +1
- timer reloads SPAWN_INTERVAL-1.
REQ-011 SPAWN, timer == 0, all slots active: no spawn; timer SHALL stay 0 (retry next frame).
REQ-012 DONE SHALL assert update_done for exactly one cycle, then return to IDLE; latency frame -> update_done = N_SLOTS+2 cycles.
REQ-013 frame pulses while busy or in DONE SHALL be ignored.
REQ-014 en falling mid-pass SHALL NOT abort the pass.
REQ-015 hit_mask[i]=1 SHALL clear active[i] in that cycle, in any state. It overrides UPDATE of slot i (position unchanged) and spawn into slot i in the same cycle.
REQ-016 clear=1 SHALL, next edge and in any state:
- set active to 0
- force IDLE, with no update_done
- reload the timer
- leave positions held.
REQ-017 LFSR SHALL be 16-bit Galois (x^16+x^14+x^13+x^11+1), advancing every clock, never zero.

Reset
REQ-018 On rst=1, asynchronously:
- active=0; all ast_x/ast_y=0; all dx=0
- state=IDLE, busy=0, update_done=0
- timer=SPAWN_INTERVAL-1, lfsr=16'hACE1.
REQ-019 Reset mid-pass SHALL abandon the pass with no update_done.

Structure
REQ-020 Package game_pkg SHALL hold H_RES, V_RES, SCREEN_CORDW, the FSM state enum and the dx encoding constants.
REQ-021 The LFSR SHALL be sub-module lfsr16 (ports clk_pix, rst, q[15:0]); everything else stays in asteroid_scheduler.

Verification
REQ-022 Bench SHALL cover:
- SPAWN_INTERVAL=2, en=1, two frames -> frame 1: no spawn, timer 0; frame 2: active=8'h01, ast_y[0]=0, ast_x[0] in 64..575; update_done 10 cycles after each frame.
- Slot 0 spawned, 160 further frames -> ast_y[0] steps 3,6,...,477; at 480 active[0]=0.
- All 8 slots active, spawn due -> no change, timer holds 0; hit_mask=8'h04 -> next frame spawns into slot 2.
- hit_mask[3] pulsed on the UPDATE cycle of idx=3 -> active[3]=0, ast_x[3]/ast_y[3] unchanged.
- clear pulsed at idx=4 -> next cycle busy=0, active=0, no update_done; rst mid-pass -> all outputs at reset values immediately.
- en=0 with frame pulses -> busy never asserts, outputs constant.

Source files
------------

// File: rtl/game_pkg.sv
// Shared screen geometry, scheduler FSM states and asteroid direction encoding.
// Direction is stored as a 2-bit two's-complement step so the reset value 0 means "no drift".
package game_pkg;

    localparam int H_RES        = 640;
    localparam int V_RES        = 480;
    localparam int SCREEN_CORDW = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        SPAWN  = 2'd2,
        DONE   = 2'd3
    } state_e;

    typedef logic [1:0] dx_t;

    localparam dx_t DX_NONE  = 2'b00;
    localparam dx_t DX_RIGHT = 2'b01;
    localparam dx_t DX_LEFT  = 2'b11;

    // Random bits 00 -> left, 10 -> right, 01/11 -> straight down.
    function automatic dx_t dx_decode(input logic [1:0] bits);
        case (bits)
            2'b00:   return DX_LEFT;
            2'b10:   return DX_RIGHT;
            default: return DX_NONE;
        endcase
    endfunction

    function automatic logic [SCREEN_CORDW-1:0] dx_delta(input dx_t dx);
        case (dx)
            DX_LEFT:  return '1;
            DX_RIGHT: return SCREEN_CORDW'(1);
            default:  return '0;
        endcase
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
// Seeded non-zero, so the sequence never reaches the all-zero lock-up state.
module lfsr16 (
    input  logic        clk_pix,
    input  logic        rst,
    output logic [15:0] q
);

    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] TAPS = 16'hB400;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
    end

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/asteroid_scheduler.sv
// Per-frame asteroid slot manager: walks every slot once per frame moving it down,
// retires slots that leave the screen, then spawns into the lowest free slot on a timer.
module asteroid_scheduler #(
    parameter int N_SLOTS        = 8,
    parameter int SPAWN_INTERVAL = 30,
    parameter int DY             = 3,
    parameter int H_RES          = game_pkg::H_RES,
    parameter int V_RES          = game_pkg::V_RES,
    parameter int SCREEN_CORDW   = game_pkg::SCREEN_CORDW
) (
    input  logic                                  clk_pix,
    input  logic                                  rst,
    input  logic                                  frame,
    input  logic                                  en,
    input  logic                                  clear,
    input  logic [N_SLOTS-1:0]                    hit_mask,
    output logic [N_SLOTS-1:0][SCREEN_CORDW-1:0]  ast_x,
    output logic [N_SLOTS-1:0][SCREEN_CORDW-1:0]  ast_y,
    output logic [N_SLOTS-1:0]                    active,
    output logic                                  busy,
    output logic                                  update_done
);

    import game_pkg::*;

    localparam int IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int TMR_W = $clog2(SPAWN_INTERVAL) + 1;

    localparam logic [TMR_W-1:0]        TMR_RELOAD = TMR_W'(SPAWN_INTERVAL - 1);
    localparam logic [IDX_W-1:0]        IDX_LAST   = IDX_W'(N_SLOTS - 1);
    localparam logic [SCREEN_CORDW-1:0] X_LIM      = SCREEN_CORDW'(H_RES);
    localparam logic [SCREEN_CORDW-1:0] Y_LIM      = SCREEN_CORDW'(V_RES);
    localparam logic [SCREEN_CORDW-1:0] STEP_Y     = SCREEN_CORDW'(DY);
    localparam logic [SCREEN_CORDW-1:0] X_BASE     = SCREEN_CORDW'(64);

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [TMR_W-1:0]          timer_q, timer_d;
    logic                      do_update;
    logic                      do_spawn;

    logic [15:0]               lfsr_w;
    logic [4:0]                unused_lfsr_bits;
    logic [N_SLOTS-1:0]        active_w;
    logic                      spawn_found;
    logic [IDX_W-1:0]          spawn_sel;
    logic [SCREEN_CORDW-1:0]   spawn_x;
    dx_t                       spawn_dx;

    lfsr16 u_lfsr (
        .clk_pix (clk_pix),
        .rst     (rst),
        .q       (lfsr_w)
    );

    assign unused_lfsr_bits = lfsr_w[15:11];
    assign spawn_x          = SCREEN_CORDW'(lfsr_w[8:0]) + X_BASE;
    assign spawn_dx         = dx_decode(lfsr_w[10:9]);

    // Descending scan so the lowest free index is the last one written.
    always_comb begin
        spawn_found = 1'b0;
        spawn_sel   = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!active_w[i]) begin
                spawn_found = 1'b1;
                spawn_sel   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        do_update = 1'b0;
        do_spawn  = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame && en) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                end
            end
            UPDATE: begin
                do_update = 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = SPAWN;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            SPAWN: begin
                state_d = DONE;
                if (timer_q != '0) begin
                    timer_d = timer_q - TMR_W'(1);
                end else if (spawn_found && !hit_mask[spawn_sel]) begin
                    // A blocked spawn leaves the timer at zero so the next frame retries.
                    do_spawn = 1'b1;
                    timer_d  = TMR_RELOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (clear) begin
            state_d   = IDLE;
            timer_d   = TMR_RELOAD;
            do_update = 1'b0;
            do_spawn  = 1'b0;
        end
    end

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            timer_q <= TMR_RELOAD;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
        end
    end

    assign busy        = (state_q == UPDATE) || (state_q == SPAWN);
    assign update_done = (state_q == DONE);

    generate
        for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
            logic [SCREEN_CORDW-1:0] x_q, x_d, y_q, y_d;
            logic [SCREEN_CORDW-1:0] x_step, y_step;
            dx_t                     dx_q, dx_d;
            logic                    act_q, act_d;
            logic                    sel_upd, sel_spawn;

            assign x_step    = x_q + dx_delta(dx_q);
            assign y_step    = y_q + STEP_Y;
            assign sel_upd   = do_update && (idx_q == IDX_W'(gi)) && act_q;
            assign sel_spawn = do_spawn && (spawn_sel == IDX_W'(gi));

            // Priority, lowest to highest: move, spawn, hit, clear.
            always_comb begin
                x_d   = x_q;
                y_d   = y_q;
                dx_d  = dx_q;
                act_d = act_q;
                if (sel_upd) begin
                    x_d = x_step;
                    y_d = y_step;
                    if ((y_step >= Y_LIM) || (x_step >= X_LIM)) begin
                        act_d = 1'b0;
                    end
                end
                if (sel_spawn) begin
                    x_d   = spawn_x;
                    y_d   = '0;
                    dx_d  = spawn_dx;
                    act_d = 1'b1;
                end
                if (hit_mask[gi]) begin
                    x_d   = x_q;
                    y_d   = y_q;
                    dx_d  = dx_q;
                    act_d = 1'b0;
                end
                if (clear) begin
                    act_d = 1'b0;
                end
            end

            always_ff @(posedge clk_pix or posedge rst) begin
                if (rst) begin
                    x_q   <= '0;
                    y_q   <= '0;
                    dx_q  <= DX_NONE;
                    act_q <= 1'b0;
                end else begin
                    x_q   <= x_d;
                    y_q   <= y_d;
                    dx_q  <= dx_d;
                    act_q <= act_d;
                end
            end

            assign ast_x[gi]    = x_q;
            assign ast_y[gi]    = y_q;
            assign active_w[gi] = act_q;
        end
    endgenerate

    assign active = active_w;

endmodule
